// File: rtl/mod_arbiter_if.sv
// -----------------------------------------------------------------------------
// mod_arbiter_if
//   Bundles the requester-facing and mod-unit-facing signals of mod_arbiter.
//
//   Requester side : req[1:0], a0/b0, a1/b1 (operands), gnt[1:0], done[1:0],
//                    result, err, busy
//   Mod-unit side  : mod_start, mod_a, mod_b (to the unit),
//                    mod_result, mod_done (from the unit)
//
//   Modports
//     slave  : the arbiter's view (consumes requests, drives grants and
//              the mod-unit command).
//     master : the environment's view (requesters plus the mod unit).
// -----------------------------------------------------------------------------
interface mod_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        req;
  logic [DATA_W-1:0] a0;
  logic [DATA_W-1:0] b0;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic [DATA_W-1:0] result;
  logic              err;
  logic              busy;
  logic              mod_start;
  logic [DATA_W-1:0] mod_a;
  logic [DATA_W-1:0] mod_b;
  logic [DATA_W-1:0] mod_result;
  logic              mod_done;

  modport slave (
    input  req, a0, b0, a1, b1, mod_result, mod_done,
    output gnt, done, result, err, busy, mod_start, mod_a, mod_b
  );

  modport master (
    output req, a0, b0, a1, b1, mod_result, mod_done,
    input  gnt, done, result, err, busy, mod_start, mod_a, mod_b
  );
endinterface

// File: rtl/mod_arbiter.sv
// -----------------------------------------------------------------------------
// mod_arbiter
//   Shares one multi-cycle modulo unit between two requesters. A round-robin
//   arbiter grants one requester at a time, latches its operands, runs the
//   mod unit with a start/done level handshake and returns the remainder with
//   a one-cycle done pulse. Divide-by-zero is answered locally (err=1) without
//   touching the mod unit; a unit that never answers is aborted after TIMEOUT
//   cycles of mod_start (err=1, result=0).
//
//   Parameters
//     TIMEOUT : max cycles mod_start may stay high without mod_done (>= 1)
//     DATA_W  : operand / result width
//
//   Ports
//     clk  : single clock, rising edge
//     rst  : synchronous, active-high reset
//     bus  : mod_arbiter_if.slave (requests, operands, grants, completions,
//            and the mod-unit handshake)
//
//   All outputs are registered; busy is decoded from the state register.
// -----------------------------------------------------------------------------
module mod_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int DATA_W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  mod_arbiter_if.slave  bus
);

  // The counter is at least 16 bits and wide enough to hold TIMEOUT itself.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
  // Value of the counter in the last cycle mod_start is allowed to stay high.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t            state_q,     state_nxt;
  logic [1:0]        gnt_q,       gnt_nxt;
  logic [1:0]        done_q,      done_nxt;
  logic              err_q,       err_nxt;
  logic [DATA_W-1:0] result_q,    result_nxt;
  logic              mod_start_q, mod_start_nxt;
  logic [DATA_W-1:0] op_a_q,      op_a_nxt;
  logic [DATA_W-1:0] op_b_q,      op_b_nxt;
  logic [CNT_W-1:0]  cnt_q,       cnt_nxt;
  logic              last_q,      last_nxt;   // index of the last requester served

  logic              sel;         // requester that would win in IDLE this cycle
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              cur;         // requester currently holding the grant

  // Round-robin pick: on contention the requester not served last wins;
  // a lone request wins outright.
  function automatic logic rr_pick(input logic [1:0] r, input logic last);
    if (r == 2'b11) begin
      return ~last;
    end
    return r[1];
  endfunction

  assign sel   = rr_pick(bus.req, last_q);
  assign sel_a = sel ? bus.a1 : bus.a0;
  assign sel_b = sel ? bus.b1 : bus.b0;
  assign cur   = gnt_q[1];

  // ---- next-state / next-output decode ------------------------------------
  always_comb begin
    state_nxt     = state_q;
    gnt_nxt       = gnt_q;
    done_nxt      = 2'b00;        // done and err are single-cycle pulses
    err_nxt       = 1'b0;
    result_nxt    = result_q;
    mod_start_nxt = mod_start_q;
    op_a_nxt      = op_a_q;
    op_b_nxt      = op_b_q;
    cnt_nxt       = cnt_q;
    last_nxt      = last_q;

    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          gnt_nxt  = {sel, ~sel};
          op_a_nxt = sel_a;
          op_b_nxt = sel_b;
          cnt_nxt  = '0;
          if (sel_b == '0) begin
            // Divide-by-zero is answered here; DRAIN then sees mod_done low
            // and returns to IDLE one cycle later, closing the grant.
            done_nxt   = {sel, ~sel};
            err_nxt    = 1'b1;
            result_nxt = '0;
            last_nxt   = sel;
            state_nxt  = DRAIN;
          end else begin
            mod_start_nxt = 1'b1;
            state_nxt     = LAUNCH;
          end
        end
      end

      LAUNCH: begin
        cnt_nxt = cnt_q + 1'b1;
        if (bus.mod_done) begin
          result_nxt    = bus.mod_result;
          mod_start_nxt = 1'b0;
          done_nxt      = gnt_q;
          last_nxt      = cur;
          state_nxt     = DRAIN;
        end else if (cnt_q >= TO_LAST) begin
          mod_start_nxt = 1'b0;
          done_nxt      = gnt_q;
          err_nxt       = 1'b1;
          result_nxt    = '0;
          last_nxt      = cur;
          state_nxt     = DRAIN;
        end
      end

      DRAIN: begin
        // Wait for the unit to release mod_done so a stale level is never
        // mistaken for the next operation's completion.
        if (!bus.mod_done) begin
          gnt_nxt   = 2'b00;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt     = IDLE;
        gnt_nxt       = 2'b00;
        mod_start_nxt = 1'b0;
      end
    endcase
  end

  // ---- state / output registers -------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      err_q       <= 1'b0;
      result_q    <= '0;
      mod_start_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_nxt;
      gnt_q       <= gnt_nxt;
      done_q      <= done_nxt;
      err_q       <= err_nxt;
      result_q    <= result_nxt;
      mod_start_q <= mod_start_nxt;
      op_a_q      <= op_a_nxt;
      op_b_q      <= op_b_nxt;
      cnt_q       <= cnt_nxt;
      last_q      <= last_nxt;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.result    = result_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.mod_start = mod_start_q;
  assign bus.mod_a     = op_a_q;
  assign bus.mod_b     = op_b_q;

endmodule

// File: tb/tb_mod_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mod_arbiter
//   Self-checking bench for mod_arbiter with a behavioural mod unit stub.
//   Expected completions are pushed to a queue when stimulus is driven; a
//   negedge monitor records every observed done pulse, and each test task
//   pops and compares them.
// -----------------------------------------------------------------------------
module tb_mod_arbiter;
  localparam int DATA_W   = 32;
  localparam int TO       = 16;
  localparam int STUB_LAT = 2;

  typedef struct packed {
    logic [1:0]        done;
    logic              err;
    logic [DATA_W-1:0] result;
  } cpl_t;

  logic clk = 1'b0;
  logic rst;
  logic stub_hang;

  int   n_checks = 0;
  int   n_pass   = 0;

  cpl_t exp_q[$];
  cpl_t obs_q[$];
  int   obs_rd = 0;

  int   start_hi    = 0;
  int   start_rises = 0;
  int   inv_bad     = 0;
  logic start_prev  = 1'b0;
  int   lat;

  mod_arbiter_if #(.DATA_W(DATA_W)) tif();

  mod_arbiter #(.TIMEOUT(TO), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif)
  );

  always #5 clk = ~clk;

  // Mod unit stub: answers a%b STUB_LAT+1 cycles after start, holds mod_done
  // until start drops. With stub_hang set it never answers.
  always @(posedge clk) begin
    if (rst || tif.mod_start !== 1'b1) begin
      tif.mod_done   <= 1'b0;
      lat            <= 0;
      if (rst) tif.mod_result <= '0;
    end else if (!stub_hang) begin
      if (lat == STUB_LAT) begin
        tif.mod_done   <= 1'b1;
        tif.mod_result <= tif.mod_a % tif.mod_b;
      end else begin
        lat <= lat + 1;
      end
    end
  end

  // Monitor: records completions and mod_start activity, flags invariant breaks.
  always @(negedge clk) begin
    if (tif.done != 2'b00) obs_q.push_back(cpl_t'{tif.done, tif.err, tif.result});
    if (tif.mod_start === 1'b1) start_hi++;
    if (tif.mod_start === 1'b1 && start_prev !== 1'b1) start_rises++;
    start_prev = tif.mod_start;
    if (rst !== 1'b1 &&
        (tif.done == 2'b11 || tif.gnt == 2'b11 ||
         (tif.done == 2'b00 && tif.err !== 1'b0)))
      inv_bad++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (obs_q.size() >= obs_rd + n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_gnt(input logic [1:0] g, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (tif.gnt === g) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (tif.busy === 1'b0 && tif.gnt === 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    tif.req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [8*DATA_W-1:0] dummy;
    dummy = '0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (tif.gnt === 2'b00) n_pass++; else $display("FAIL reset_gnt: got %b required 00", tif.gnt);
    n_checks++; if (tif.done === 2'b00) n_pass++; else $display("FAIL reset_done: got %b required 00", tif.done);
    n_checks++; if (tif.result === dummy[DATA_W-1:0]) n_pass++; else $display("FAIL reset_result: got %0h required 0", tif.result);
    n_checks++; if (tif.err === 1'b0) n_pass++; else $display("FAIL reset_err: got %b required 0", tif.err);
    n_checks++; if (tif.busy === 1'b0) n_pass++; else $display("FAIL reset_busy: got %b required 0", tif.busy);
    n_checks++; if (tif.mod_start === 1'b0) n_pass++; else $display("FAIL reset_mod_start: got %b required 0", tif.mod_start);
    n_checks++; if (tif.mod_a === '0) n_pass++; else $display("FAIL reset_mod_a: got %0h required 0", tif.mod_a);
    n_checks++; if (tif.mod_b === '0) n_pass++; else $display("FAIL reset_mod_b: got %0h required 0", tif.mod_b);
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    cpl_t e, o;
    exp_q.push_back(cpl_t'{2'b01, 1'b0, 32'd2});
    @(negedge clk);
    tif.req = 2'b01; tif.a0 = 32'd10; tif.b0 = 32'd4;
    @(negedge clk); #1;
    n_checks++; if (tif.gnt === 2'b01) n_pass++; else $display("FAIL single_gnt: got %b required 01", tif.gnt);
    n_checks++; if (tif.busy === 1'b1) n_pass++; else $display("FAIL single_busy: got %b required 1", tif.busy);
    n_checks++; if (tif.mod_start === 1'b1) n_pass++; else $display("FAIL single_start: got %b required 1", tif.mod_start);
    n_checks++; if (tif.mod_a === 32'd10 && tif.mod_b === 32'd4) n_pass++;
    else $display("FAIL single_operands: got %0d/%0d required 10/4", tif.mod_a, tif.mod_b);
    tif.req = 2'b00;
    wait_obs(1, 50, ok);
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL single_wait_done: got timeout required done pulse");
    e = exp_q.pop_front();
    o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : '0;
    obs_rd++;
    n_checks++; if (o === e) n_pass++;
    else $display("FAIL single_cpl: got done=%b err=%b result=%0d required done=%b err=%b result=%0d",
                  o.done, o.err, o.result, e.done, e.err, e.result);
    wait_idle(20, ok);
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL single_idle: got busy=%b required 0", tif.busy);
  endtask

  task automatic test_div0();
    bit ok;
    int r0;
    cpl_t e, o;
    r0 = start_rises;
    exp_q.push_back(cpl_t'{2'b10, 1'b1, 32'd0});
    @(negedge clk);
    tif.req = 2'b10; tif.a1 = 32'd5; tif.b1 = 32'd0;
    @(negedge clk); #1;
    tif.req = 2'b00;
    n_checks++; if (tif.gnt === 2'b10 && tif.done === 2'b10 && tif.err === 1'b1) n_pass++;
    else $display("FAIL div0_pulse: got gnt=%b done=%b err=%b required 10/10/1", tif.gnt, tif.done, tif.err);
    wait_obs(1, 10, ok);
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL div0_wait_done: got timeout required done pulse");
    e = exp_q.pop_front();
    o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : '0;
    obs_rd++;
    n_checks++; if (o === e) n_pass++;
    else $display("FAIL div0_cpl: got done=%b err=%b result=%0d required done=%b err=%b result=%0d",
                  o.done, o.err, o.result, e.done, e.err, e.result);
    wait_idle(20, ok);
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL div0_idle: got busy=%b required 0", tif.busy);
    n_checks++; if (start_rises == r0) n_pass++;
    else $display("FAIL div0_no_start: got %0d rises required 0", start_rises - r0);
  endtask

  task automatic test_both();
    bit ok;
    int r0;
    cpl_t e, o;
    apply_reset();
    r0 = start_rises;
    exp_q.push_back(cpl_t'{2'b01, 1'b0, 32'd3});
    exp_q.push_back(cpl_t'{2'b10, 1'b0, 32'd2});
    @(negedge clk);
    tif.req = 2'b11;
    tif.a0 = 32'd87;  tif.b0 = 32'd6;
    tif.a1 = 32'd100; tif.b1 = 32'd7;
    wait_gnt(2'b01, 10, ok);
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL both_first_gnt: got %b required 01", tif.gnt);
    tif.req = 2'b10;
    tif.a0 = 32'd999; tif.b0 = 32'd1;   // must not disturb the latched copy
    @(negedge clk); #1;
    n_checks++; if (tif.mod_a === 32'd87 && tif.mod_b === 32'd6) n_pass++;
    else $display("FAIL both_operand_hold: got %0d/%0d required 87/6", tif.mod_a, tif.mod_b);
    wait_gnt(2'b10, 50, ok);
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL both_second_gnt: got %b required 10", tif.gnt);
    tif.req = 2'b00;
    wait_obs(2, 50, ok);
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL both_wait_done: got timeout required 2 done pulses");
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : '0;
      obs_rd++;
      n_checks++; if (o === e) n_pass++;
      else $display("FAIL both_cpl[%0d]: got done=%b err=%b result=%0d required done=%b err=%b result=%0d",
                    i, o.done, o.err, o.result, e.done, e.err, e.result);
    end
    wait_idle(20, ok);
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL both_idle: got busy=%b required 0", tif.busy);
    n_checks++; if (start_rises - r0 == 2) n_pass++;
    else $display("FAIL both_start_gap: got %0d start rises required 2", start_rises - r0);
  endtask

  task automatic test_alternate();
    bit ok;
    cpl_t e, o;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) exp_q.push_back(cpl_t'{2'b01, 1'b0, 32'd2});
      else            exp_q.push_back(cpl_t'{2'b10, 1'b0, 32'd3});
    end
    @(negedge clk);
    tif.a0 = 32'd10; tif.b0 = 32'd4;
    tif.a1 = 32'd23; tif.b1 = 32'd5;
    tif.req = 2'b11;
    wait_obs(6, 300, ok);
    tif.req = 2'b00;
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL alt_wait_done: got timeout required 6 done pulses");
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : '0;
      obs_rd++;
      n_checks++; if (o === e) n_pass++;
      else $display("FAIL alt_cpl[%0d]: got done=%b err=%b result=%0d required done=%b err=%b result=%0d",
                    i, o.done, o.err, o.result, e.done, e.err, e.result);
    end
    wait_idle(20, ok);
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL alt_idle: got busy=%b required 0", tif.busy);
  endtask

  task automatic test_timeout();
    bit ok;
    int h0, r0;
    cpl_t e, o;
    stub_hang = 1'b1;
    h0 = start_hi;
    r0 = start_rises;
    exp_q.push_back(cpl_t'{2'b01, 1'b1, 32'd0});
    @(negedge clk);
    tif.req = 2'b01; tif.a0 = 32'd50; tif.b0 = 32'd7;
    wait_gnt(2'b01, 10, ok);
    tif.req = 2'b00;
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL to_gnt: got %b required 01", tif.gnt);
    wait_obs(1, 100, ok);
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL to_wait_done: got timeout required done pulse");
    e = exp_q.pop_front();
    o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : '0;
    obs_rd++;
    n_checks++; if (o === e) n_pass++;
    else $display("FAIL to_cpl: got done=%b err=%b result=%0d required done=%b err=%b result=%0d",
                  o.done, o.err, o.result, e.done, e.err, e.result);
    n_checks++; if (start_hi - h0 == TO) n_pass++;
    else $display("FAIL to_start_len: got %0d cycles required %0d", start_hi - h0, TO);
    n_checks++; if (start_rises - r0 == 1) n_pass++;
    else $display("FAIL to_start_rises: got %0d required 1", start_rises - r0);
    wait_idle(20, ok);
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL to_idle: got busy=%b required 0", tif.busy);
    stub_hang = 1'b0;
  endtask

  task automatic test_midreset();
    bit ok;
    int base;
    cpl_t e, o;
    stub_hang = 1'b1;
    @(negedge clk);
    tif.req = 2'b01; tif.a0 = 32'd10; tif.b0 = 32'd4;
    wait_gnt(2'b01, 10, ok);
    tif.req = 2'b00;
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL mr_gnt: got %b required 01", tif.gnt);
    repeat (3) @(negedge clk);
    base = obs_q.size();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (tif.gnt === 2'b00) n_pass++; else $display("FAIL mr_gnt_rst: got %b required 00", tif.gnt);
    n_checks++; if (tif.done === 2'b00) n_pass++; else $display("FAIL mr_done_rst: got %b required 00", tif.done);
    n_checks++; if (tif.result === '0) n_pass++; else $display("FAIL mr_result_rst: got %0h required 0", tif.result);
    n_checks++; if (tif.err === 1'b0) n_pass++; else $display("FAIL mr_err_rst: got %b required 0", tif.err);
    n_checks++; if (tif.busy === 1'b0) n_pass++; else $display("FAIL mr_busy_rst: got %b required 0", tif.busy);
    n_checks++; if (tif.mod_start === 1'b0) n_pass++; else $display("FAIL mr_start_rst: got %b required 0", tif.mod_start);
    n_checks++; if (tif.mod_a === '0 && tif.mod_b === '0) n_pass++;
    else $display("FAIL mr_operands_rst: got %0d/%0d required 0/0", tif.mod_a, tif.mod_b);
    rst = 1'b0;
    stub_hang = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (obs_q.size() == base) n_pass++;
    else $display("FAIL mr_no_done: got %0d done pulses required 0", obs_q.size() - base);
    exp_q.push_back(cpl_t'{2'b01, 1'b0, 32'd2});
    tif.req = 2'b01; tif.a0 = 32'd10; tif.b0 = 32'd4;
    wait_gnt(2'b01, 10, ok);
    tif.req = 2'b00;
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL mr_regrant: got %b required 01", tif.gnt);
    wait_obs(1, 50, ok);
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL mr_wait_done: got timeout required done pulse");
    e = exp_q.pop_front();
    o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : '0;
    obs_rd++;
    n_checks++; if (o === e) n_pass++;
    else $display("FAIL mr_cpl: got done=%b err=%b result=%0d required done=%b err=%b result=%0d",
                  o.done, o.err, o.result, e.done, e.err, e.result);
    wait_idle(20, ok);
    n_checks++; if (ok === 1'b1) n_pass++; else $display("FAIL mr_idle: got busy=%b required 0", tif.busy);
  endtask

  task automatic test_invariants();
    n_checks++; if (inv_bad == 0) n_pass++;
    else $display("FAIL invariants: got %0d violating cycles required 0", inv_bad);
    n_checks++; if (obs_q.size() == obs_rd) n_pass++;
    else $display("FAIL extra_done: got %0d unexpected done pulses required 0", obs_q.size() - obs_rd);
  endtask

  initial begin
    rst       = 1'b1;
    stub_hang = 1'b0;
    tif.req   = 2'b00;
    tif.a0    = '0;
    tif.b0    = '0;
    tif.a1    = '0;
    tif.b1    = '0;
    test_reset();
    test_single();
    test_div0();
    test_both();
    test_alternate();
    test_timeout();
    test_midreset();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
